// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the multiplexed hex 7-segment scan driver.
// Segment patterns are active-low, bit0 = a ... bit6 = g.
package seg_scan_pkg;

   localparam logic [6:0] SEG_OFF = 7'b1111111;

   // Entry k is the glyph for hex value k; the leftmost literal is entry 15.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'b0001110,  // F
      7'b0000110,  // E
      7'b0100001,  // d
      7'b1000110,  // C
      7'b0000011,  // b
      7'b0001000,  // A
      7'b0010000,  // 9
      7'b0000000,  // 8
      7'b1111000,  // 7
      7'b0000010,  // 6
      7'b0010010,  // 5
      7'b0011001,  // 4
      7'b0110000,  // 3
      7'b0100100,  // 2
      7'b1111001,  // 1
      7'b1000000   // 0
   };

   typedef enum logic {
      GAP   = 1'b0,
      DRIVE = 1'b1
   } state_t;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low 7-segment glyph lookup.
module seg_hex_decode
   import seg_scan_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit hex 7-segment scan driver with all-off guard gaps.
// Optional leading-zero suppression is compiled in when SEG_LZS_EN is defined.
module seg_scan_driver
   import seg_scan_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 50000,
   parameter int GAP_CYCLES = 50
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [4*NUM_DIGITS-1:0] DATA_IN,
   input  logic [NUM_DIGITS-1:0]   BLANK_IN,
   input  logic                    LOAD,
   output logic [6:0]              LED_SEG,
   output logic [NUM_DIGITS-1:0]   LED_AN,
   output logic                    FRAME_DONE
);

   localparam int CNT_MAX = (SCAN_DIV > GAP_CYCLES) ? SCAN_DIV : GAP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CNT_W-1:0] DRIVE_END = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_END   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
   localparam bit               HAS_GAP   = (GAP_CYCLES > 0);

   state_t                         state, state_nxt;
   logic [IDX_W-1:0]               idx, idx_nxt, idx_adv, drive_idx;
   logic [CNT_W-1:0]               cnt, cnt_nxt;
   logic [NUM_DIGITS-1:0][3:0]     shadow_data;
   logic [NUM_DIGITS-1:0]          shadow_blank;
   logic [NUM_DIGITS-1:0]          lzs;
   logic [NUM_DIGITS-1:0]          an_mask;
   logic [6:0]                     dec_seg;
   logic [6:0]                     seg_nxt;
   logic [NUM_DIGITS-1:0]          an_nxt;
   logic                           done_nxt;
   logic                           drive_blank;

   // The digit about to be driven: the current idx when leaving GAP, or the
   // advanced idx when a zero-length gap chains DRIVE straight into DRIVE.
   assign idx_adv   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
   assign drive_idx = (state == DRIVE) ? idx_adv : idx;

   seg_hex_decode u_dec (
      .nibble (shadow_data[drive_idx]),
      .seg    (dec_seg)
   );

`ifdef SEG_LZS_EN
   // Digit k goes dark when it and every more significant nibble are zero.
   always_comb begin
      lzs = '0;
      for (int k = 1; k < NUM_DIGITS; k++) begin
         lzs[k] = 1'b1;
         for (int j = k; j < NUM_DIGITS; j++) begin
            if (shadow_data[j] != 4'h0) lzs[k] = 1'b0;
         end
      end
   end
`else
   assign lzs = '0;
`endif

   assign drive_blank = shadow_blank[drive_idx] | lzs[drive_idx];

   always_comb begin
      an_mask = '1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (drive_idx == IDX_W'(k)) an_mask[k] = 1'b0;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cnt_nxt   = cnt + 1'b1;
      seg_nxt   = LED_SEG;
      an_nxt    = LED_AN;
      done_nxt  = 1'b0;
      case (state)
         GAP: begin
            if (!HAS_GAP || cnt == GAP_END) begin
               state_nxt = DRIVE;
               cnt_nxt   = '0;
               an_nxt    = an_mask;
               seg_nxt   = drive_blank ? SEG_OFF : dec_seg;
            end
         end
         DRIVE: begin
            if (cnt == DRIVE_END) begin
               cnt_nxt  = '0;
               idx_nxt  = idx_adv;
               done_nxt = (idx == LAST_IDX);
               if (HAS_GAP) begin
                  state_nxt = GAP;
                  an_nxt    = '1;
                  seg_nxt   = SEG_OFF;
               end else begin
                  state_nxt = DRIVE;
                  an_nxt    = an_mask;
                  seg_nxt   = drive_blank ? SEG_OFF : dec_seg;
               end
            end
         end
         default: begin
            state_nxt = GAP;
            cnt_nxt   = '0;
            an_nxt    = '1;
            seg_nxt   = SEG_OFF;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state        <= GAP;
         idx          <= '0;
         cnt          <= '0;
         shadow_data  <= '0;
         shadow_blank <= '0;
         LED_SEG      <= SEG_OFF;
         LED_AN       <= '1;
         FRAME_DONE   <= 1'b0;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         cnt        <= cnt_nxt;
         LED_SEG    <= seg_nxt;
         LED_AN     <= an_nxt;
         FRAME_DONE <= done_nxt;
         if (LOAD) begin
            shadow_data  <= DATA_IN;
            shadow_blank <= BLANK_IN;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (4 digits, 4-cycle drive, 1-cycle gap).
// Expectations switch to blanked leading zeros when SEG_LZS_EN is defined.
module tb_seg_scan_driver;

   localparam int ND   = 4;
   localparam int SD   = 4;
   localparam int GC   = 1;
   localparam int SLOT = SD + GC;

   localparam logic [6:0] S0  = 7'b1000000;
   localparam logic [6:0] S1  = 7'b1111001;
   localparam logic [6:0] S2  = 7'b0100100;
   localparam logic [6:0] S3  = 7'b0110000;
   localparam logic [6:0] S4  = 7'b0011001;
   localparam logic [6:0] S5  = 7'b0010010;
   localparam logic [6:0] S8  = 7'b0000000;
   localparam logic [6:0] OFF = 7'b1111111;
`ifdef SEG_LZS_EN
   localparam logic [6:0] LZ = OFF;
`else
   localparam logic [6:0] LZ = S0;
`endif

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          LOAD = 1'b0;
   logic [15:0]   DATA_IN = '0;
   logic [3:0]    BLANK_IN = '0;
   logic [6:0]    LED_SEG;
   logic [3:0]    LED_AN;
   logic          FRAME_DONE;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   seg_scan_driver #(
      .NUM_DIGITS (ND),
      .SCAN_DIV   (SD),
      .GAP_CYCLES (GC)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .DATA_IN    (DATA_IN),
      .BLANK_IN   (BLANK_IN),
      .LOAD       (LOAD),
      .LED_SEG    (LED_SEG),
      .LED_AN     (LED_AN),
      .FRAME_DONE (FRAME_DONE)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Checks ncyc cycles starting at the DRIVE entry of digit 0; each observation
   // is {FRAME_DONE, LED_AN, LED_SEG}. Optional LOAD lands on that entry edge.
   task automatic run_frame(input string tag, input int ncyc, input bit ld,
                            input logic [15:0] d, input logic [3:0] b,
                            input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2, input logic [6:0] e3);
      logic [6:0]  e [4];
      logic [3:0]  an_exp;
      logic [11:0] exp;
      int          slot;
      int          pos;
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
      if (ld) begin
         DATA_IN  = d;
         BLANK_IN = b;
         LOAD     = 1'b1;
      end
      for (int c = 0; c < ncyc; c++) begin
         @(negedge CLK);
         LOAD = 1'b0;
         slot = c / SLOT;
         pos  = c % SLOT;
         if (pos < SD) begin
            an_exp       = 4'b1111;
            an_exp[slot] = 1'b0;
            exp          = {1'b0, an_exp, e[slot]};
         end else begin
            exp = {(slot == ND - 1), 4'b1111, OFF};
         end
         chk($sformatf("%s c%0d", tag, c), {20'd0, FRAME_DONE, LED_AN, LED_SEG}, {20'd0, exp});
      end
   endtask

   initial begin
      RST = 1'b1;
      repeat (3) begin
         @(negedge CLK);
         chk("reset", {20'd0, FRAME_DONE, LED_AN, LED_SEG}, {20'd0, 1'b0, 4'b1111, OFF});
      end
      RST = 1'b0;

      // Load 1234 on the first DRIVE entry: digit 0 still shows the old zero.
      run_frame("f1_1234_load", 20, 1'b1, 16'h1234, 4'b0000, S0, S3, S2, S1);
      run_frame("f2_1234",      20, 1'b0, 16'h0,    4'b0000, S4, S3, S2, S1);

      DATA_IN  = 16'hABCD;
      BLANK_IN = 4'b1111;
      run_frame("f3_noload",    20, 1'b0, 16'h0,    4'b0000, S4, S3, S2, S1);
      run_frame("f4_noload",    20, 1'b0, 16'h0,    4'b0000, S4, S3, S2, S1);

      run_frame("f5_8888_load", 20, 1'b1, 16'h8888, 4'b0100, S4, S8, OFF, S8);
      run_frame("f6_8888_blk",  20, 1'b0, 16'h0,    4'b0000, S8, S8, OFF, S8);

      run_frame("f7_0050_load", 20, 1'b1, 16'h0050, 4'b0000, S8, S5, LZ, LZ);
      run_frame("f8_0050",      20, 1'b0, 16'h0,    4'b0000, S0, S5, LZ, LZ);

      run_frame("f9_0000_load", 20, 1'b1, 16'h0000, 4'b0000, S0, LZ, LZ, LZ);
      run_frame("f10_0000",     20, 1'b0, 16'h0,    4'b0000, S0, LZ, LZ, LZ);

      // Stop during digit 2's drive period and reset there.
      run_frame("f11_partial",  12, 1'b0, 16'h0,    4'b0000, S0, LZ, LZ, LZ);
      RST = 1'b1;
      @(negedge CLK);
      chk("reset_mid", {20'd0, FRAME_DONE, LED_AN, LED_SEG}, {20'd0, 1'b0, 4'b1111, OFF});
      RST = 1'b0;
      run_frame("f12_after_rst", 20, 1'b0, 16'h0,   4'b0000, S0, LZ, LZ, LZ);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
